// File: rtl/cpu_pipe_pkg.sv
// Shared constants and state encoding for the in-order pipeline stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a; the stage registers that import this package handle it.
package cpu_pipe_pkg;

  localparam int PIPE_INSTR_W = 32;
  localparam int PIPE_ADDR_W  = 32;

  // Bubble word injected when a stage holds nothing (flush, drain, reset).
  localparam logic [PIPE_INSTR_W-1:0] PIPE_NOP_INSTR = 32'h0000_0000;

  // Occupancy of a two-entry (main + skid) stage register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One {instr, pc} storage slot with load enable and a parameterised reset value.
// Latency: 1 cycle from ld_i to the outputs.
// Backpressure: none; the caller decides when to load.
module pipe_slot #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [INSTR_W-1:0] RST_INSTR = '0,
  parameter logic [ADDR_W-1:0]  RST_PC    = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ld_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  // Capture the pair when loaded; reset discards any held content.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= RST_INSTR;
      pc_q    <= RST_PC;
    end else if (ld_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pipe_reg_ifid_skid.sv
// IF->ID stage register with a one-entry skid buffer, flush-to-bubble and a stall counter.
// Latency: 1 cycle in_fire -> out_valid; full throughput while out_ready stays high.
// Backpressure: in_ready is registered (low only when both slots hold data), so no comb path from out_ready.
module pipe_reg_ifid_skid
  import cpu_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = PIPE_INSTR_W,
  parameter int                 ADDR_W    = PIPE_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = PIPE_NOP_INSTR,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  pipe_state_e        state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   stall_q;

  logic               main_ld, skid_ld;
  logic [INSTR_W-1:0] main_instr_d, skid_instr_d, main_instr, skid_instr;
  logic [ADDR_W-1:0]  main_pc_d, skid_pc_d, main_pc, skid_pc;

  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Next occupancy and slot loads; flush overrides every other transition.
  always_comb begin
    state_d      = state_q;
    main_ld      = 1'b0;
    main_instr_d = in_instr;
    main_pc_d    = in_pc;
    skid_ld      = 1'b0;
    skid_instr_d = in_instr;
    skid_pc_d    = in_pc;
    if (flush) begin
      // Drop everything, including a same-cycle input; pc is kept for debug visibility.
      state_d      = ST_EMPTY;
      main_ld      = 1'b1;
      main_instr_d = NOP_INSTR;
      main_pc_d    = main_pc;
      skid_ld      = 1'b1;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d      = ST_EMPTY;
            main_ld      = 1'b1;
            main_instr_d = NOP_INSTR;
            main_pc_d    = main_pc;
          end
        end
        ST_FULL: begin
          // Skid is older than anything fetch could present, so it moves up first.
          if (out_fire) begin
            state_d      = ST_ONE;
            main_ld      = 1'b1;
            main_instr_d = skid_instr;
            main_pc_d    = skid_pc;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and registered handshake outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Saturating count of cycles where decode withholds ready from a valid entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  pipe_slot #(
    .INSTR_W   (INSTR_W),
    .ADDR_W    (ADDR_W),
    .RST_INSTR (NOP_INSTR),
    .RST_PC    (RESET_PC)
  ) u_main (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .ld_i    (main_ld),
    .instr_i (main_instr_d),
    .pc_i    (main_pc_d),
    .instr_o (main_instr),
    .pc_o    (main_pc)
  );

  pipe_slot #(
    .INSTR_W   (INSTR_W),
    .ADDR_W    (ADDR_W),
    .RST_INSTR ('0),
    .RST_PC    ('0)
  ) u_skid (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .ld_i    (skid_ld),
    .instr_i (skid_instr_d),
    .pc_i    (skid_pc_d),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = main_instr;
  assign out_pc    = main_pc;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_reg_ifid_skid.sv
// Bench for pipe_reg_ifid_skid: directed scenarios followed by randomized traffic.
// Latency: expected behaviour comes from a queue model of accepted-but-unconsumed entries.
// Backpressure: the model derives ready from queue occupancy (capacity two).
module tb_pipe_reg_ifid_skid;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = '0;
  logic [31:0]   in_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] stall_cnt;

  pipe_reg_ifid_skid #(
    .INSTR_W   (32),
    .ADDR_W    (32),
    .NOP_INSTR (NOP),
    .RESET_PC  (RPC),
    .CNT_W     (CW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entries fetch handed over that decode has not yet taken.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_pc = RPC;
  int          m_stall = 0;

  // Monitor: compare outputs mid-cycle, then advance the model over the coming edge.
  always @(negedge CLK) begin
    bit   mv, mr;
    ent_t e;
    if (!RST_N) begin
      exp_q.delete();
      m_pc    = RPC;
      m_stall = 0;
    end
    mv = (exp_q.size() > 0);
    mr = (exp_q.size() < 2);
    chk("in_ready", {31'b0, in_ready}, {31'b0, mr});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    if (mv) begin
      chk("out_instr", out_instr, exp_q[0].instr);
      chk("out_pc", out_pc, exp_q[0].pc);
    end else begin
      chk("idle_instr", out_instr, NOP);
      chk("idle_pc", out_pc, m_pc);
    end
    chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, m_stall);
    if (RST_N) begin
      if (mv) m_pc = exp_q[0].pc;
      if (mv && !out_ready && m_stall < SAT) m_stall++;
      if (mv && out_ready) void'(exp_q.pop_front());
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && mr) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(posedge CLK);
    #1;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    logic        iv, ordy, fl;

    // Reset held for a few edges.
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_pc", out_pc, RPC);

    // Back-to-back stream with decode always ready.
    drive(1'b1, 32'h2001_0005, 32'd4, 1'b1, 1'b0);
    drive(1'b1, 32'h2002_0006, 32'd8, 1'b1, 1'b0);
    drive(1'b1, 32'h0022_1820, 32'd12, 1'b1, 1'b0);
    idle(3);
    chk("stream_stall", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);

    // Decode stalls for three cycles while fetch keeps pushing.
    drive(1'b1, 32'hA000_0001, 32'h10, 1'b1, 1'b0);
    drive(1'b1, 32'hA000_0002, 32'h14, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0003, 32'h18, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0004, 32'h1C, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0005, 32'h20, 1'b1, 1'b0);
    drive(1'b1, 32'hA000_0006, 32'h24, 1'b1, 1'b0);
    idle(5);
    chk("bp_stall", {{(32-CW){1'b0}}, stall_cnt}, 32'd3);

    // Flush while full with fetch still presenting.
    drive(1'b1, 32'hB000_0001, 32'h40, 1'b0, 1'b0);
    drive(1'b1, 32'hB000_0002, 32'h44, 1'b0, 1'b0);
    drive(1'b1, 32'hB000_0003, 32'h48, 1'b0, 1'b0);
    drive(1'b1, 32'hB000_0004, 32'h4C, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_instr", out_instr, 32'h0000_0000);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_pc", out_pc, 32'h40);
    idle(2);

    // Long stall drives the counter into saturation.
    drive(1'b1, 32'hC000_0001, 32'h80, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CW) + 5; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall_sat", {{(32-CW){1'b0}}, stall_cnt}, SAT);
    idle(2);

    // Asynchronous reset while both slots are occupied.
    drive(1'b1, 32'hD000_0001, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'hD000_0002, 32'hC4, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_pc", out_pc, RPC);
    chk("arst_instr", out_instr, NOP);
    chk("arst_stall", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    RST_N = 1'b1;
    idle(2);

    // Random traffic; the monitor checks order, stability and flush drops.
    pc = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      fl   = ($urandom_range(19) == 0);
      drive(iv, $urandom, pc, ordy, fl);
      pc = pc + 32'd4;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
